alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared 64-bit ALU.
//
// Each operation runs IDLE (grant and operand capture), then EXEC (ALU output
// registered), then RESP (response held until the granted requester takes it).
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   req_valid/ready per-requester request handshake (ready is combinational in IDLE)
//   req_a/b/op      per-requester operands and ALUControl code
//   rsp_valid/ready per-requester response handshake
//   rsp_result/zero/err  shared response payload, meaningful while rsp_valid != 0
//   busy            high whenever the FSM is not in IDLE
//   op_count        number of completed response handshakes (wrapping)
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][63:0] req_a,
    input  logic [1:0][63:0] req_b,
    input  logic [1:0][3:0]  req_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy,
    output logic [31:0]      op_count
);

    localparam int unsigned DW = 64;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            ptr_q;
    logic            gnt_q;
    logic [DW-1:0]   a_q, b_q;
    logic [OW-1:0]   op_q;
    logic [DW-1:0]   result_q;
    logic            zero_q, err_q;
    logic [1:0]      rsp_valid_q;
    logic [CW-1:0]   op_count_q;

    logic            gnt_c;
    logic            grant_c;
    logic            rsp_done_c;
    logic            op_legal_c;
    logic [DW-1:0]   alu_result;
    logic            alu_zero;

    // Shared ALU, fed only from the captured operand registers
    alu u_alu (
        .a          (a_q),
        .b          (b_q),
        .ALUControl (op_q),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    // Opcode legality; illegal codes report an error with a cleared payload
    always_comb begin
        op_legal_c = 1'b0;
        case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: op_legal_c = 1'b1;
            default:                                     op_legal_c = 1'b0;
        endcase
    end

    // Next state, grant selection and request acceptance
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        grant_c   = 1'b0;
        gnt_c     = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    gnt_c     = req_valid[ptr_q] ? ptr_q : ~ptr_q;
                    grant_c   = 1'b1;
                    // Gated by reset so acceptance is never shown while reset is asserted
                    req_ready = reset ? (gnt_c ? 2'b10 : 2'b01) : 2'b00;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready[gnt_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Only the granted requester's rsp_ready can complete the response
    assign rsp_done_c = (state_q == S_RESP) && rsp_ready[gnt_q];

    // State, pointer, operand, response and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= RR_INIT;
            gnt_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            op_count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_c) begin
                gnt_q <= gnt_c;
                a_q   <= req_a[gnt_c];
                b_q   <= req_b[gnt_c];
                op_q  <= req_op[gnt_c];
            end
            if (state_q == S_EXEC) begin
                result_q    <= op_legal_c ? alu_result : '0;
                zero_q      <= op_legal_c & alu_zero;
                err_q       <= ~op_legal_c;
                rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            end
            if (rsp_done_c) begin
                rsp_valid_q <= 2'b00;
                ptr_q       <= ~gnt_q;
                op_count_q  <= op_count_q + CW'(1);
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != S_IDLE);
    assign op_count   = op_count_q;

endmodule

// alu: combinational 64-bit ALU (AND, OR, ADD, SUB, PASS B); other codes give 0.
// Ports: a, b operands; ALUControl operation code; result; zero = (result == 0).
module alu (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  ALUControl,
    output logic [63:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (ALUControl)
            4'b0000: result = a & b;
            4'b0001: result = a | b;
            4'b0010: result = a + b;
            4'b0110: result = a - b;
            4'b0111: result = b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter; directed cases followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_alu_arbiter;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][63:0] req_a;
    logic [1:0][63:0] req_b;
    logic [1:0][3:0]  req_op;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [63:0]      rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic             busy;
    logic [31:0]      op_count;

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester-side view: pending operation per requester
    logic        pend_v  [2];
    logic [63:0] pend_a  [2];
    logic [63:0] pend_b  [2];
    logic [3:0]  pend_op [2];

    // Model state: who holds priority, how many responses completed
    logic        m_ptr;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_alu(input logic [3:0] op, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] r,
                                    output logic z, output logic e);
        e = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = b;
            default: begin r = 64'd0; e = 1'b1; end
        endcase
        z = !e && (r == 64'd0);
    endfunction

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] op);
        pend_v[i] = 1'b1; pend_a[i] = a; pend_b[i] = b; pend_op[i] = op;
    endtask

    task automatic apply_pend();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = pend_v[i];
            req_a[i]     = pend_a[i];
            req_b[i]     = pend_b[i];
            req_op[i]    = pend_op[i];
        end
    endtask

    // One full transaction (or one idle cycle when nothing is pending).
    // Entered and left just after a rising edge.
    task automatic run_txn(input int hold, input bit poke_other);
        logic        g;
        logic [63:0] er;
        logic        ez, ee;
        logic [1:0]  rr;
        apply_pend();
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("idle_op_count", op_count, m_cnt);
        chk("idle_rsp_valid", rsp_valid, 2'b00);
        chk("idle_busy", busy, 0);
        if (!(pend_v[0] || pend_v[1])) begin
            chk("idle_req_ready", req_ready, 2'b00);
            @(posedge clk); #1;
            return;
        end
        g = pend_v[m_ptr] ? m_ptr : ~m_ptr;
        chk("grant", req_ready, g ? 2'b10 : 2'b01);
        ref_alu(pend_op[g], pend_a[g], pend_b[g], er, ez, ee);
        @(posedge clk); #1;
        pend_v[g] = 1'b0;
        apply_pend();
        @(negedge clk);
        chk("exec_req_ready", req_ready, 2'b00);
        chk("exec_rsp_valid", rsp_valid, 2'b00);
        chk("exec_busy", busy, 1);
        @(posedge clk); #1;
        for (int k = 0; k <= hold; k++) begin
            rr = 2'b00;
            if (poke_other) rr[~g] = 1'($urandom_range(0, 1));
            if (k == hold) rr[g] = 1'b1;
            rsp_ready = rr;
            @(negedge clk);
            chk("rsp_valid", rsp_valid, g ? 2'b10 : 2'b01);
            chk("rsp_result", rsp_result, er);
            chk("rsp_zero", rsp_zero, ez);
            chk("rsp_err", rsp_err, ee);
            chk("resp_req_ready", req_ready, 2'b00);
            chk("resp_busy", busy, 1);
            chk("resp_op_count", op_count, m_cnt);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b00;
        m_ptr = ~g;
        m_cnt = m_cnt + 32'd1;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] legal [5];
        legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010;
        legal[3] = 4'b0110; legal[4] = 4'b0111;
        if ($urandom_range(0, 5) == 0) return 4'($urandom);
        return legal[$urandom_range(0, 4)];
    endfunction

    task automatic rand_fill();
        logic [63:0] a, b;
        for (int i = 0; i < 2; i++) begin
            if (!pend_v[i] && $urandom_range(0, 2) != 0) begin
                a = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       b = a;
                    1:       b = 64'd0;
                    default: b = {$urandom, $urandom};
                endcase
                set_req(i, a, b, rand_op());
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 1'b0; pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = '0;
        end
        m_ptr = 1'b0;
        m_cnt = 32'd0;

        // Reset values
        #12;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_result", rsp_result, 64'd0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Both valid together: requester 0 first, then requester 1, pointer back to 0
        set_req(0, 64'd27586970463758451, 64'd27586970463758451, 4'b0110);
        set_req(1, 64'd5, 64'd0, 4'b0111);
        run_txn(0, 1'b0);
        run_txn(0, 1'b0);

        // ADD on requester 0 with immediate consumption
        set_req(0, 64'd93846573825364758, 64'd27313240968594, 4'b0010);
        run_txn(0, 1'b0);

        // Illegal opcode on requester 1
        set_req(1, 64'hDEAD_BEEF, 64'h1234, 4'b0011);
        run_txn(0, 1'b0);

        // Wrap-around arithmetic
        set_req(0, 64'd9223372036854775807, 64'd2, 4'b0010);
        run_txn(0, 1'b0);
        set_req(1, 64'd9223372036854775809, 64'd2, 4'b0110);
        run_txn(0, 1'b0);

        // Backpressure for 5 cycles with the other requester waiting and poking rsp_ready
        set_req(0, 64'hF0F0, 64'h0FF0, 4'b0000);
        set_req(1, 64'hF000, 64'h000F, 4'b0001);
        run_txn(5, 1'b1);
        run_txn(0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            rand_fill();
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 4; t++) run_txn(0, 1'b0);

        // Reset during EXEC discards the in-flight operation
        set_req(1, 64'd7, 64'd9, 4'b0010);
        apply_pend();
        @(negedge clk);
        chk("abort_grant", req_ready, m_ptr == 1'b1 || !pend_v[0] ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        pend_v[1] = 1'b0;
        apply_pend();
        #2;
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 2'b00);
        chk("abort_busy", busy, 0);
        chk("abort_op_count", op_count, 32'd0);
        chk("abort_result", rsp_result, 64'd0);
        chk("abort_req_ready", req_ready, 2'b00);
        m_ptr = 1'b0;
        m_cnt = 32'd0;
        @(posedge clk); #1;
        reset = 1'b1;

        // First grant possible immediately after release; no stale response appears
        set_req(1, 64'd100, 64'd100, 4'b0110);
        run_txn(1, 1'b0);
        for (int t = 0; t < 30; t++) begin
            rand_fill();
            run_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
